// File: rtl/bayer_window_gen.sv
// Streaming 5x5 neighbourhood generator for a raster-ordered Bayer pixel stream.
// Emits one masked window per accepted pixel once two lines plus two pixels are buffered.
module bayer_window_gen #(
    parameter int unsigned IMG_W        = 640,
    parameter int unsigned IMG_H        = 480,
    parameter logic [1:0]  BAYER_ORIGIN = 2'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_pixel,
    input  logic       in_sof,
    output logic       out_valid,
    output logic       out_sof,
    output logic       out_eof,
    output logic [7:0] pixel_window [0:4][0:4],
    output logic [0:4] pixel_row_en,
    output logic [0:4] pixel_col_en,
    output logic [1:0] bayer_center_pixel
);

    localparam int unsigned N    = IMG_W * IMG_H;
    localparam int unsigned L    = 2 * IMG_W + 2;
    localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned KW   = $clog2(N + L + 1);

    typedef enum logic [1:0] {StWaitSof, StFill, StRun, StFlush} state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [ColW-1:0] col_q, col_d, addr;
    logic [RowW-1:0] ctr_row_q, ctr_row_d;
    logic [ColW-1:0] ctr_col_q, ctr_col_d;
    logic            accept, sof_acc, phantom, advance, emit;
    logic [7:0]      pix_in;

    logic [7:0] lb_mem [0:3][0:IMG_W-1];
    logic [7:0] new_col [0:4];
    logic [7:0] win_q [0:4][0:4];
    logic [7:0] win_d [0:4][0:4];

    logic       out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
    logic [7:0] window_q [0:4][0:4];
    logic [7:0] window_d [0:4][0:4];
    logic [0:4] row_en_q, row_en_d, col_en_q, col_en_d;
    logic [1:0] bayer_q, bayer_d;

    assign in_ready = !rst && (state_q != StFlush);
    assign accept   = in_valid && in_ready;
    assign sof_acc  = accept && in_sof;
    // Flush feeds zero-valued pseudo-pixels past the frame end; they only land in masked rows.
    assign phantom  = (state_q == StFlush) && (k_q < KW'(N + L));
    assign advance  = sof_acc || phantom ||
                      (accept && (state_q == StFill || state_q == StRun));
    assign emit     = !sof_acc && (phantom || (accept && state_q == StRun) ||
                      (accept && state_q == StFill && k_q == KW'(L)));
    assign addr     = sof_acc ? '0 : col_q;
    assign pix_in   = phantom ? 8'd0 : in_pixel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StWaitSof;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitSof: if (sof_acc) state_d = StFill;
            StFill, StRun: begin
                if (sof_acc) begin
                    state_d = StFill;
                end else if (accept && k_q == KW'(N - 1)) begin
                    state_d = StFlush;
                end else if (accept && k_q == KW'(L)) begin
                    state_d = StRun;
                end
            end
            StFlush: if (k_q == KW'(N + L)) state_d = StWaitSof;
            default: state_d = StWaitSof;
        endcase
    end

    always_comb begin
        k_d       = k_q;
        col_d     = col_q;
        ctr_row_d = ctr_row_q;
        ctr_col_d = ctr_col_q;
        if (sof_acc) begin
            k_d       = KW'(1);
            col_d     = ColW'(1);
            ctr_row_d = '0;
            ctr_col_d = '0;
        end else if (advance) begin
            k_d   = k_q + KW'(1);
            col_d = (col_q == ColW'(IMG_W - 1)) ? '0 : col_q + ColW'(1);
        end
        if (emit) begin
            if (ctr_col_q == ColW'(IMG_W - 1)) begin
                ctr_col_d = '0;
                ctr_row_d = ctr_row_q + RowW'(1);
            end else begin
                ctr_col_d = ctr_col_q + ColW'(1);
            end
        end
    end

    // Line storage shifts one row up per column visit, so lb_mem[0] holds the oldest row.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int i = 0; i < 3; i++) lb_mem[i][addr] <= lb_mem[i+1][addr];
            lb_mem[3][addr] <= pix_in;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) new_col[i] = lb_mem[i][addr];
        new_col[4] = pix_in;
        win_d = win_q;
        if (advance) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 4; j++) win_d[i][j] = win_q[i][j+1];
                win_d[i][4] = new_col[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        win_q     <= win_d;
        k_q       <= k_d;
        col_q     <= col_d;
        ctr_row_q <= ctr_row_d;
        ctr_col_q <= ctr_col_d;
    end

    always_comb begin
        int rr, cc;
        out_valid_d = emit;
        out_sof_d   = emit && ctr_row_q == '0 && ctr_col_q == '0;
        out_eof_d   = emit && ctr_row_q == RowW'(IMG_H - 1) && ctr_col_q == ColW'(IMG_W - 1);
        bayer_d     = BAYER_ORIGIN ^ {ctr_row_q[0], ctr_col_q[0]};
        for (int i = 0; i < 5; i++) begin
            rr          = int'(ctr_row_q) - 2 + i;
            cc          = int'(ctr_col_q) - 2 + i;
            row_en_d[i] = (rr >= 0) && (rr < int'(IMG_H));
            col_en_d[i] = (cc >= 0) && (cc < int'(IMG_W));
        end
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                window_d[i][j] = (row_en_d[i] && col_en_d[j]) ? win_d[i][j] : 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            row_en_q    <= '0;
            col_en_q    <= '0;
            bayer_q     <= '0;
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) window_q[i][j] <= 8'd0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            if (emit) begin
                row_en_q <= row_en_d;
                col_en_q <= col_en_d;
                bayer_q  <= bayer_d;
                window_q <= window_d;
            end
        end
    end

    assign out_valid          = out_valid_q;
    assign out_sof            = out_sof_q;
    assign out_eof            = out_eof_q;
    assign pixel_window       = window_q;
    assign pixel_row_en       = row_en_q;
    assign pixel_col_en       = col_en_q;
    assign bayer_center_pixel = bayer_q;

endmodule
